// File: rtl/countdown_timer.sv
// countdown_timer: loadable N-bit down-counter with IDLE/RUN/DONE control FSM.
// Ports:
//   clk       - system clock, all state updates on the rising edge
//   rst       - synchronous active-low reset (reloads initValue, forces IDLE)
//   a         - decrement enable, effective only in RUN
//   start     - leave IDLE and begin counting
//   load      - synchronous reload of initValue, forces IDLE
//   reload_en - on expiry, 1 = reload and keep running, 0 = return to IDLE
//   initValue - start value sampled on reset, load and auto-reload
//   count     - registered counter value
//   busy      - high while in RUN
//   done      - one-cycle expiry pulse, high while in DONE
module countdown_timer #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a,
    input  logic         start,
    input  logic         load,
    input  logic         reload_en,
    input  logic [N-1:0] initValue,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            count_d = initValue;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = start ? RUN : IDLE;
                RUN: begin
                    // zero is caught before decrementing so the count never wraps
                    if (count_q == '0) begin
                        state_d = DONE;
                    end else if (a) begin
                        count_d = count_q - N'(1);
                        state_d = (count_q == N'(1)) ? DONE : RUN;
                    end
                end
                DONE: begin
                    count_d = reload_en ? initValue : count_q;
                    state_d = reload_en ? RUN : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= initValue;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end
    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable N-bit down-counter with a start/expire state machine. It is the counterpart to the team's loadable up-counter, which shares the clk/rst/a/initValue interface.
- Counts down from initValue to zero on enabled cycles. Signals expiry with a one-cycle done pulse, then optionally auto-reloads.
- Used as a programmable delay/timeout generator alongside the counter blocks in the lab designs.

Parameters:
- N, 2, counter width in bits (N >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low. rst=0 at a rising clk edge resets the block.
- a  input  1  decrement enable; count steps only in RUN with a=1.
- start  input  1  begin counting from IDLE; ignored in RUN and DONE.
- load  input  1  synchronous reload of initValue into count; forces IDLE.
- reload_en  input  1  on expiry, 1 = reload initValue and continue running; 0 = stop in IDLE.
- initValue  input  N  start value, sampled on reset, load and auto-reload.
- count  output  N  current counter value (registered).
- busy  output  1  high while state == RUN.
- done  output  1  high for exactly the one cycle the state is DONE.

Behaviour:
- States: IDLE, RUN, DONE. Held in a registered state variable. busy and done decode directly from state, with no combinational path from inputs.
- Priority at each rising edge, highest first: rst=0, then load, then the state transition rules below.
- Reset (rst=0): count <= initValue, state <= IDLE. Resulting outputs: busy=0, done=0. Reset mid-count abandons the count immediately, with no done pulse.
- load=1 (rst=1): count <= initValue, state <= IDLE in any state. A DONE in progress is cancelled, so done=0 the next cycle.
- IDLE:
  - start=1 -> RUN; count unchanged.
  - start=0 -> stay in IDLE; count holds.
  - a is ignored in IDLE.
- RUN:
  - count == 0 -> DONE, independent of a; count stays 0. This covers a start or reload with a zero initValue.
  - a=1 and count == 1 -> count <= 0, state <= DONE.
  - a=1 and count > 1 -> count <= count - 1.
  - a=0 -> hold count and state.
  - start in RUN is ignored.
- DONE (lasts exactly one cycle):
  - reload_en=1 -> count <= initValue, state <= RUN. Back-to-back periods have no gap cycle.
  - reload_en=0 -> state <= IDLE; count stays 0.
- Arithmetic: unsigned modulo-2^N, but count never wraps below 0 because the RUN rules intercept count == 0 and count == 1.
- Latency: from the start edge to the done edge, the block takes 1 + initValue enabled cycles when a is held at 1.
- initValue is only sampled on reset, load and reload; changes at other times have no effect on count.
- An X/Z-free reset is required: after the first edge with rst=0, all outputs are defined.

Test Plan (N=2 unless stated):
- Reset: rst=0 for one edge with initValue=2'b10 -> count=2, busy=0, done=0. Hold rst=1 and start=0 for 3 edges -> count stays 2, busy stays 0.
- Basic countdown: after reset (count=2), pulse start for 1 edge, a=1, reload_en=0.
  - Edge1: busy=1, count=2.
  - Edge2: count=1.
  - Edge3: count=0, done=1, busy=0.
  - Edge4: done=0, state IDLE, count=0.
- Enable gating: in RUN with count=2, drive a=0 for 3 edges -> count stays 2, busy=1. Then a=1 -> count=1 on the next edge.
- Auto-reload: initValue=2'b11, reload_en=1, a=1, start.
  - Count sequence 3,2,1,0 with done=1 in the 0 cycle.
  - Next edge: count=3, busy=1, done=0, with no idle cycle.
  - Done pulses repeat every 4 cycles.
- Reset/load mid-operation:
  - In RUN at count=1, change initValue to 2'b11 and assert rst=0 for one edge -> count=3, IDLE, done never asserted.
  - Repeat using load=1 instead of rst -> same result.
  - Assert load during the DONE cycle with reload_en=1 -> count=initValue, IDLE, busy=0.
- Zero start: initValue=0, load, then start -> edge1 RUN with count=0, edge2 done=1, edge3 IDLE. Also verify that start asserted during RUN has no effect on count or state.
